// File: rtl/alarm_ui_pkg.sv
// Shared types, BCD limits and BCD increment helpers for the alarm front-panel controller.
package alarm_ui_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        T_HR   = 3'd1,
        T_MIN  = 3'd2,
        A_HR   = 3'd3,
        A_MIN  = 3'd4,
        RING   = 3'd5,
        ACK    = 3'd6,
        SNZ_LD = 3'd7
    } ui_state_t;

    typedef enum logic {
        KIND_STOP   = 1'b0,
        KIND_SNOOZE = 1'b1
    } stop_kind_t;

    localparam logic [5:0] HR_MAX  = 6'h23;
    localparam logic [7:0] MIN_MAX = 8'h59;

    // Hours are kept as {tens[1:0], units[3:0]}
    function automatic logic [5:0] bcd_hr_inc(input logic [5:0] hr);
        if (hr == HR_MAX)
            return 6'h00;
        else if (hr[3:0] == 4'd9)
            return {hr[5:4] + 2'd1, 4'd0};
        else
            return {hr[5:4], hr[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_min_inc(input logic [7:0] mm);
        if (mm == MIN_MAX)
            return 8'h00;
        else if (mm[3:0] == 4'd9)
            return {mm[7:4] + 4'd1, 4'd0};
        else
            return {mm[7:4], mm[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/alarm_bcd_adder.sv
// Combinational hh:mm + k minutes (k in 1..9) in BCD, wrapping at 24 h.
module alarm_bcd_adder
    import alarm_ui_pkg::*;
(
    input  logic [5:0] hr,
    input  logic [7:0] min,
    input  logic [3:0] k,
    output logic [5:0] sum_hr,
    output logic [7:0] sum_min
);

    logic [4:0] units;
    logic [4:0] units_adj;

    always_comb begin
        units     = {1'b0, min[3:0]} + {1'b0, k};
        units_adj = units - 5'd10;
        sum_hr    = hr;
        sum_min   = min;
        if (units > 5'd9) begin
            sum_min[3:0] = units_adj[3:0];
            if (min[7:4] == 4'd5) begin
                sum_min[7:4] = 4'd0;
                sum_hr       = bcd_hr_inc(hr);
            end else begin
                sum_min[7:4] = min[7:4] + 4'd1;
            end
        end else begin
            sum_min[3:0] = units[3:0];
        end
    end

endmodule

// File: rtl/alarm_ui_ctrl.sv
// Front-panel edit FSM and ring/snooze sequencer driving the alarm_clock load and alarm inputs.
module alarm_ui_ctrl #(
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    input  logic       btn_arm,
    input  logic [1:0] cur_hr_1,
    input  logic [3:0] cur_hr_0,
    input  logic [3:0] cur_min_1,
    input  logic [3:0] cur_min_0,
    input  logic       alarm_in,
    output logic [1:0] hr_in_1,
    output logic [3:0] hr_in_0,
    output logic [3:0] min_in_1,
    output logic [3:0] min_in_0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       STOP_alarm,
    output logic       AL_ON,
    output logic [2:0] ui_state,
    output logic [7:0] edit_hh,
    output logic [7:0] edit_mm
);
    import alarm_ui_pkg::*;

    ui_state_t  state, state_n;
    stop_kind_t kind, kind_n;
    logic [3:0] snz_cnt, snz_cnt_n;
    logic       snz_phase, snz_phase_n;
    logic [5:0] edit_hr, edit_hr_n, shadow_hr, shadow_hr_n;
    logic [5:0] out_hr, out_hr_n, sum_hr, sum_hr_n, add_hr;
    logic [7:0] edit_min, edit_min_n, shadow_min, shadow_min_n;
    logic [7:0] out_min, out_min_n, sum_min, sum_min_n, add_min;
    logic       ld_time_n, ld_alarm_n, stop_n, al_on_n;
    logic       p_stop, p_snz, p_mode, p_inc, p_arm, ring_req;

    // Only the highest-priority button of a cycle survives
    assign p_stop   = btn_stop;
    assign p_snz    = btn_snooze & ~btn_stop;
    assign p_mode   = btn_mode & ~btn_snooze & ~btn_stop;
    assign p_inc    = btn_inc & ~btn_mode & ~btn_snooze & ~btn_stop;
    assign p_arm    = btn_arm & ~btn_inc & ~btn_mode & ~btn_snooze & ~btn_stop;
    assign ring_req = alarm_in & AL_ON;

    alarm_bcd_adder u_adder (
        .hr      ({cur_hr_1, cur_hr_0}),
        .min     ({cur_min_1, cur_min_0}),
        .k       (4'(SNOOZE_MIN)),
        .sum_hr  (add_hr),
        .sum_min (add_min)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)
            state <= RUN;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            RUN:     if (ring_req) state_n = RING; else if (p_mode) state_n = T_HR;
            T_HR:    if (p_mode) state_n = T_MIN;
            T_MIN:   if (p_mode) state_n = A_HR;
            A_HR:    if (p_mode) state_n = A_MIN;
            A_MIN:   if (p_mode) state_n = RUN;
            RING:    if (p_stop || p_snz) state_n = ACK;
            ACK:     if (!alarm_in) state_n = SNZ_LD;
            SNZ_LD:  if (snz_phase) state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    always_comb begin
        edit_hr_n    = edit_hr;
        edit_min_n   = edit_min;
        shadow_hr_n  = shadow_hr;
        shadow_min_n = shadow_min;
        out_hr_n     = out_hr;
        out_min_n    = out_min;
        sum_hr_n     = sum_hr;
        sum_min_n    = sum_min;
        kind_n       = kind;
        snz_cnt_n    = snz_cnt;
        snz_phase_n  = 1'b0;
        ld_time_n    = 1'b0;
        ld_alarm_n   = 1'b0;
        stop_n       = STOP_alarm;
        al_on_n      = AL_ON;
        case (state)
            RUN: begin
                if (!ring_req) begin
                    if (p_mode) begin
                        edit_hr_n  = {cur_hr_1, cur_hr_0};
                        edit_min_n = {cur_min_1, cur_min_0};
                    end else if (p_arm) begin
                        al_on_n = ~AL_ON;
                    end
                end
            end
            T_HR, A_HR: if (p_inc) edit_hr_n = bcd_hr_inc(edit_hr);
            T_MIN: begin
                if (p_mode) begin
                    out_hr_n   = edit_hr;
                    out_min_n  = edit_min;
                    ld_time_n  = 1'b1;
                    edit_hr_n  = shadow_hr;
                    edit_min_n = shadow_min;
                end else if (p_inc) begin
                    edit_min_n = bcd_min_inc(edit_min);
                end
            end
            A_MIN: begin
                if (p_mode) begin
                    shadow_hr_n  = edit_hr;
                    shadow_min_n = edit_min;
                    out_hr_n     = edit_hr;
                    out_min_n    = edit_min;
                    ld_alarm_n   = 1'b1;
                    al_on_n      = 1'b1;
                end else if (p_inc) begin
                    edit_min_n = bcd_min_inc(edit_min);
                end
            end
            RING: begin
                if (p_stop) begin
                    kind_n = KIND_STOP;
                    stop_n = 1'b1;
                end else if (p_snz) begin
                    stop_n = 1'b1;
                    if (snz_cnt < 4'(MAX_SNOOZE)) begin
                        kind_n    = KIND_SNOOZE;
                        snz_cnt_n = snz_cnt + 4'd1;
                    end else begin
                        kind_n = KIND_STOP;
                    end
                end
            end
            ACK: if (!alarm_in) stop_n = 1'b0;
            SNZ_LD: begin
                // First cycle captures now+SNOOZE_MIN, second cycle issues the load
                if (!snz_phase) begin
                    snz_phase_n = 1'b1;
                    sum_hr_n    = add_hr;
                    sum_min_n   = add_min;
                end else if (kind == KIND_SNOOZE) begin
                    out_hr_n   = sum_hr;
                    out_min_n  = sum_min;
                    ld_alarm_n = 1'b1;
                end else begin
                    if (snz_cnt != 4'd0) begin
                        out_hr_n   = shadow_hr;
                        out_min_n  = shadow_min;
                        ld_alarm_n = 1'b1;
                    end
                    snz_cnt_n = 4'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            edit_hr    <= '0;
            edit_min   <= '0;
            shadow_hr  <= '0;
            shadow_min <= '0;
            out_hr     <= '0;
            out_min    <= '0;
            sum_hr     <= '0;
            sum_min    <= '0;
            kind       <= KIND_STOP;
            snz_cnt    <= '0;
            snz_phase  <= 1'b0;
            LD_time    <= 1'b0;
            LD_alarm   <= 1'b0;
            STOP_alarm <= 1'b0;
            AL_ON      <= 1'b0;
        end else begin
            edit_hr    <= edit_hr_n;
            edit_min   <= edit_min_n;
            shadow_hr  <= shadow_hr_n;
            shadow_min <= shadow_min_n;
            out_hr     <= out_hr_n;
            out_min    <= out_min_n;
            sum_hr     <= sum_hr_n;
            sum_min    <= sum_min_n;
            kind       <= kind_n;
            snz_cnt    <= snz_cnt_n;
            snz_phase  <= snz_phase_n;
            LD_time    <= ld_time_n;
            LD_alarm   <= ld_alarm_n;
            STOP_alarm <= stop_n;
            AL_ON      <= al_on_n;
        end
    end

    assign hr_in_1  = out_hr[5:4];
    assign hr_in_0  = out_hr[3:0];
    assign min_in_1 = out_min[7:4];
    assign min_in_0 = out_min[3:0];
    assign ui_state = state;
    assign edit_hh  = {2'b00, edit_hr};
    assign edit_mm  = edit_min;

endmodule

// File: tb/tb_alarm_ui_ctrl.sv
// Directed bench for alarm_ui_ctrl: edit/commit, wraps, ring/stop/snooze sequencing, async reset.
module tb_alarm_ui_ctrl;

    logic       clk, areset_n;
    logic       btn_mode, btn_inc, btn_snooze, btn_stop, btn_arm;
    logic [1:0] cur_hr_1;
    logic [3:0] cur_hr_0, cur_min_1, cur_min_0;
    logic       alarm_in;
    logic [1:0] hr_in_1;
    logic [3:0] hr_in_0, min_in_1, min_in_0;
    logic       LD_time, LD_alarm, STOP_alarm, AL_ON;
    logic [2:0] ui_state;
    logic [7:0] edit_hh, edit_mm;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] B_STOP = 5'b10000, B_SNZ = 5'b01000, B_MODE = 5'b00100,
                           B_INC = 5'b00010, B_ARM = 5'b00001;

    alarm_ui_ctrl #(.SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
        .clk(clk), .areset_n(areset_n),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_snooze(btn_snooze),
        .btn_stop(btn_stop), .btn_arm(btn_arm),
        .cur_hr_1(cur_hr_1), .cur_hr_0(cur_hr_0), .cur_min_1(cur_min_1), .cur_min_0(cur_min_0),
        .alarm_in(alarm_in),
        .hr_in_1(hr_in_1), .hr_in_0(hr_in_0), .min_in_1(min_in_1), .min_in_0(min_in_0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_alarm(STOP_alarm), .AL_ON(AL_ON),
        .ui_state(ui_state), .edit_hh(edit_hh), .edit_mm(edit_mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        {btn_stop, btn_snooze, btn_mode, btn_inc, btn_arm} = b;
        tick();
        {btn_stop, btn_snooze, btn_mode, btn_inc, btn_arm} = '0;
    endtask

    task automatic set_cur(input logic [7:0] hh, input logic [7:0] mm);
        cur_hr_1  = hh[5:4];
        cur_hr_0  = hh[3:0];
        cur_min_1 = mm[7:4];
        cur_min_0 = mm[3:0];
    endtask

    function automatic logic [31:0] load_val();
        return {18'd0, hr_in_1, hr_in_0, min_in_1, min_in_0};
    endfunction

    // Ring, ignore UI buttons, acknowledge with b, release alarm, stop before the load edge
    task automatic ring_ack(input logic [4:0] b);
        alarm_in = 1'b1;
        tick();
        chk("ring_enter", 32'(ui_state), 32'd5);
        press(B_MODE | B_INC | B_ARM);
        chk("ring_ignore_ui", 32'(ui_state), 32'd5);
        chk("ring_ignore_arm", 32'(AL_ON), 32'd1);
        press(b);
        chk("ack_state", 32'(ui_state), 32'd6);
        chk("ack_stop_hi", 32'(STOP_alarm), 32'd1);
        tick();
        chk("ack_stop_held", 32'(STOP_alarm), 32'd1);
        alarm_in = 1'b0;
        tick();
        chk("snzld_state", 32'(ui_state), 32'd7);
        chk("snzld_stop_lo", 32'(STOP_alarm), 32'd0);
        tick();
        chk("snzld_no_early_ld", 32'(LD_alarm), 32'd0);
        tick();
    endtask

    task automatic snooze_round(input logic [7:0] hh, input logic [7:0] mm, input logic [31:0] exp);
        set_cur(hh, mm);
        ring_ack(B_SNZ);
        chk("snz_ld_alarm", 32'(LD_alarm), 32'd1);
        chk("snz_load_val", load_val(), exp);
        chk("snz_back_run", 32'(ui_state), 32'd0);
        tick();
        chk("snz_ld_drop", 32'(LD_alarm), 32'd0);
        chk("snz_val_hold", load_val(), exp);
    endtask

    initial begin
        areset_n = 1'b1;
        {btn_stop, btn_snooze, btn_mode, btn_inc, btn_arm} = '0;
        alarm_in = 1'b0;
        set_cur(8'h00, 8'h00);
        #2 areset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_state", 32'(ui_state), 32'd0);
        chk("rst_load", load_val(), 32'h0);
        chk("rst_ld", 32'({LD_time, LD_alarm, STOP_alarm, AL_ON}), 32'd0);
        chk("rst_edit", 32'({edit_hh, edit_mm}), 32'h0000);
        areset_n = 1'b1;
        tick();

        // Time edit: 00:00 -> 02:03, commit
        press(B_MODE);
        chk("t_hr_state", 32'(ui_state), 32'd1);
        press(B_INC);
        press(B_INC);
        chk("t_hr_inc2", 32'(edit_hh), 32'h02);
        press(B_MODE);
        chk("t_min_state", 32'(ui_state), 32'd2);
        for (int i = 0; i < 3; i++) press(B_INC);
        chk("t_min_inc3", 32'({edit_hh, edit_mm}), 32'h0203);
        press(B_MODE);
        chk("ld_time_pulse", 32'(LD_time), 32'd1);
        chk("ld_time_val", load_val(), 32'h0203);
        chk("a_hr_state", 32'(ui_state), 32'd3);
        chk("a_hr_seed", 32'({edit_hh, edit_mm}), 32'h0000);
        tick();
        chk("ld_time_one", 32'(LD_time), 32'd0);
        chk("ld_time_hold", load_val(), 32'h0203);

        // Alarm edit with hour and minute wraps, ending at 06:30
        for (int i = 0; i < 23; i++) press(B_INC);
        chk("a_hr_23", 32'(edit_hh), 32'h23);
        press(B_INC);
        chk("a_hr_wrap", 32'(edit_hh), 32'h00);
        for (int i = 0; i < 6; i++) press(B_INC);
        press(B_MODE);
        chk("a_min_state", 32'(ui_state), 32'd4);
        for (int i = 0; i < 59; i++) press(B_INC);
        chk("a_min_59", 32'({edit_hh, edit_mm}), 32'h0659);
        press(B_INC);
        chk("a_min_wrap", 32'({edit_hh, edit_mm}), 32'h0600);
        for (int i = 0; i < 30; i++) press(B_INC);
        press(B_MODE | B_INC);
        chk("ld_alarm_pulse", 32'(LD_alarm), 32'd1);
        chk("ld_alarm_val", load_val(), 32'h0630);
        chk("al_on_set", 32'(AL_ON), 32'd1);
        chk("commit_run", 32'(ui_state), 32'd0);
        tick();
        chk("ld_alarm_one", 32'(LD_alarm), 32'd0);

        press(B_ARM);
        chk("arm_off", 32'(AL_ON), 32'd0);
        press(B_ARM);
        chk("arm_on", 32'(AL_ON), 32'd1);

        // Seed from current time; alarm raised mid-edit rings once back in RUN
        set_cur(8'h12, 8'h34);
        press(B_MODE);
        chk("seed_cur", 32'({edit_hh, edit_mm}), 32'h1234);
        press(B_MODE);
        alarm_in = 1'b1;
        tick();
        chk("edit_no_ring", 32'(ui_state), 32'd2);
        press(B_MODE);
        chk("ld_time_1234", load_val(), 32'h1234);
        chk("a_hr_shadow", 32'({edit_hh, edit_mm}), 32'h0630);
        press(B_MODE);
        press(B_MODE);
        chk("recommit_run", 32'(ui_state), 32'd0);
        tick();
        chk("late_ring", 32'(ui_state), 32'd5);

        // Stop beats mode in the same cycle; count 0 so no reload
        ring_ack(B_STOP | B_MODE);
        chk("stop_no_ld", 32'(LD_alarm), 32'd0);
        chk("stop_run", 32'(ui_state), 32'd0);
        chk("stop_val_hold", load_val(), 32'h0630);

        // Three snoozes, a fourth acting as stop, then a fresh snooze
        snooze_round(8'h23, 8'h57, 32'h0002);
        snooze_round(8'h10, 8'h58, 32'h1103);
        snooze_round(8'h09, 8'h55, 32'h1000);
        set_cur(8'h14, 8'h00);
        ring_ack(B_SNZ);
        chk("snz4_reload", 32'(LD_alarm), 32'd1);
        chk("snz4_shadow", load_val(), 32'h0630);
        tick();
        snooze_round(8'h19, 8'h59, 32'h2004);

        // Asynchronous reset while acknowledging
        alarm_in = 1'b1;
        tick();
        press(B_STOP);
        chk("pre_rst_stop", 32'(STOP_alarm), 32'd1);
        #2 areset_n = 1'b0;
        #1;
        chk("async_stop", 32'(STOP_alarm), 32'd0);
        chk("async_al_on", 32'(AL_ON), 32'd0);
        chk("async_state", 32'(ui_state), 32'd0);
        chk("async_load", load_val(), 32'h0);
        alarm_in = 1'b0;
        tick();
        areset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_ld", 32'({LD_alarm, LD_time}), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_ui_ctrl.md
# alarm_ui_ctrl

User-interface and alarm-sequencing controller for `alarm_clock`. It turns debounced button pulses into BCD time/alarm edits and drives the clock's load and alarm inputs: `LD_time`, `LD_alarm`, `AL_ON` and `STOP_alarm`. It also runs snooze by reprogramming the alarm to now+`SNOOZE_MIN` and restoring the user alarm afterwards. It sits between the front-panel debouncers and the `alarm_clock` instance.

## Interface
- `SNOOZE_MIN`, 5: snooze interval in minutes, legal range 1..9.
- `MAX_SNOOZE`, 3: snoozes allowed per ring sequence; a further snooze press acts as stop.

Ports:
- `clk` in 1: system clock. Same clock as `alarm_clock`.
- `areset_n` in 1: reset, asynchronous, active-low.
- `btn_mode`, `btn_inc`, `btn_snooze`, `btn_stop`, `btn_arm` in 1 each: one-cycle pulses from the debouncers.
- `cur_hr_1` in 2, `cur_hr_0` in 4, `cur_min_1` in 4, `cur_min_0` in 4: current time (BCD) from the clock.
- `alarm_in` in 1: the clock's `Alarm` output.
- `hr_in_1` out 2, `hr_in_0` out 4, `min_in_1` out 4, `min_in_0` out 4: load data (BCD) to the clock.
- `LD_time`, `LD_alarm` out 1 each: one-cycle load strobes.
- `STOP_alarm` out 1: alarm acknowledge to the clock.
- `AL_ON` out 1: alarm enable level.
- `ui_state` out 3: encoded current state, used for display blinking.
- `edit_hh` out 8, `edit_mm` out 8: edit registers (BCD) for display.

## Operation
- States: RUN, T_HR, T_MIN, A_HR, A_MIN, RING, ACK, SNZ_LD.
- RUN:
  - `btn_mode` → T_HR. Edit registers are seeded from `cur_*`.
  - `btn_arm` toggles `AL_ON`.
  - `alarm_in`=1 and `AL_ON`=1 → RING.
- T_HR/A_HR:
  - `btn_inc` increments hours 00..23, wrapping 23→00.
  - `btn_mode` → next state (T_MIN or A_MIN).
- T_MIN/A_MIN:
  - `btn_inc` increments minutes 00..59, wrapping 59→00. The hour is untouched on wrap.
- `btn_mode` in T_MIN:
  - Drives edit registers onto `*_in` and pulses `LD_time`.
  - → A_HR, with edit registers seeded from the user-alarm shadow.
- `btn_mode` in A_MIN:
  - Writes edit registers to the shadow, drives them on `*_in` and pulses `LD_alarm`.
  - Sets `AL_ON`=1 and → RUN.
- RING:
  - `btn_stop` → ACK with `stop_kind`=STOP.
  - `btn_snooze` with snooze count < `MAX_SNOOZE` → ACK with `stop_kind`=SNOOZE and count+1. Otherwise it is treated as stop.
  - `btn_mode`/`btn_inc`/`btn_arm` are ignored.
- ACK:
  - `STOP_alarm`=1 and held until `alarm_in` is sampled 0.
  - Then `STOP_alarm`=0 and → SNZ_LD.
- SNZ_LD:
  - SNOOZE: computes now+`SNOOZE_MIN` (BCD, minute carry into hour, 23:5x wraps to 00:0x) and pulses `LD_alarm` with that time. The shadow is unchanged.
  - STOP: if count>0, reloads the shadow with an `LD_alarm` pulse; if count=0 no load is issued. The count is then cleared.
  - → RUN in both cases.
- `alarm_in` rising while in an edit state is not lost. RUN enters RING on the level as soon as it is re-entered.
- Button priority in one cycle: stop > snooze > mode > inc > arm. Lower-priority pulses in that cycle are dropped.
- `*_in` holds its last loaded value between loads.

## Timing
- All outputs are registered. A button pulse at edge n produces a response at edge n+1.
- `LD_time`/`LD_alarm` are high exactly one cycle. `*_in` is valid in that cycle and stays stable afterwards.
- Snooze path: ACK exit at edge n. The sum is registered at n+1, and `LD_alarm` fires at n+2.
- Reset values:
  - state RUN;
  - `*_in`=0, `LD_*`=0, `STOP_alarm`=0, `AL_ON`=0, `ui_state`=RUN;
  - edit registers 00:00, shadow 00:00, snooze count 0.
- Reset asserted mid-edit or mid-ACK: all outputs return to reset values immediately. No strobe is emitted.

## Structure
- Package `alarm_ui_pkg`:
  - state enum and `stop_kind` enum;
  - BCD limit constants (23, 59);
  - functions `bcd_hr_inc` and `bcd_min_inc`.
- Sub-module `alarm_bcd_adder`: combinational hh:mm + k minutes (k 1..9) in BCD with 24 h wrap. Registered by the parent.

## Test plan
- Reset, then mode, inc×2, mode, inc×3, mode → `LD_time` one-cycle pulse with 02:03. The edit then continues into alarm edit.
- Alarm edit from 23:59: inc on hour → 00, inc on minute → 00 and the hour stays 00. Commit → `LD_alarm`, `AL_ON`=1.
- Shadow 06:30, `alarm_in`=1, snooze at current 23:57 with `SNOOZE_MIN`=5 → `STOP_alarm` until `alarm_in`=0, then `LD_alarm` with 00:02.
- After 3 snoozes, a 4th snooze press → behaves as stop and reloads shadow 06:30. Snooze count is 0.
- `btn_stop` and `btn_mode` in the same RING cycle → stop wins and the state never enters T_HR. `alarm_in` during T_MIN → RING right after the commit returns to RUN.
- `areset_n` low during ACK → `STOP_alarm`=0, `AL_ON`=0 asynchronously. No `LD_alarm` is issued after release.
